tc_adder_checker: RTL and testbench

Synthesizable, parametrised stimulus generator and self-checker for N-bit adder DUTs (mirror, ripple, carry-select) in the tc_lib flow. It drives {A, B, Cin} from either a 32-bit LFSR or an exhaustive counter and computes the reference sum internally. It delays that sum to match the DUT latency, compares it against {Cout, S} and reports match, error count and a final pass/fail. It sits beside the DUT in silicon test harnesses and in mixed-signal co-simulation.

---
 rtl/tc_adder_pkg.sv | 16 +
 rtl/tc_adder_checker_if.sv | 26 ++
 rtl/tc_lfsr32.sv | 36 +++
 rtl/tc_adder_checker.sv | 176 +++++++++++++++++
 tb/tb_tc_adder_checker.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_adder_pkg.sv
// rtl/tc_adder_pkg.sv - shared types and constants for the tc_lib adder checker
package tc_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic MODE_LFSR  = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

endpackage

// File: rtl/tc_adder_checker_if.sv
// rtl/tc_adder_checker_if.sv - operand/result bus between the checker and the adder under test
interface tc_adder_checker_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output A,
        output B,
        output Cin,
        input  S,
        input  Cout
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output S,
        output Cout
    );
endinterface

// File: rtl/tc_lfsr32.sv
// rtl/tc_lfsr32.sv - 32-bit right-shifting Galois LFSR with enable and reseed on reset
module tc_lfsr32
    import tc_adder_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'h1,
    parameter logic [31:0] TAPS  = LFSR_TAPS,
    parameter int          OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] value
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_nxt;

    // Bit 0 falls out and, when set, folds the tap mask back into the shifted state.
    always_comb begin
        lfsr_nxt = {1'b0, lfsr_q[31:1]};
        if (lfsr_q[0]) begin
            lfsr_nxt = lfsr_nxt ^ TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= lfsr_nxt;
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/tc_adder_checker.sv
// rtl/tc_adder_checker.sv - stimulus generator and latency-matched self-checker for N-bit adders
module tc_adder_checker
    import tc_adder_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          LAT         = 1,
    parameter int          NUM_VECTORS = 20,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    tc_adder_checker_if.master  bus,
    output logic                match,
    output logic                chk_valid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [15:0]         vec_count
);

    localparam int          VW = 2 * WIDTH + 1;
    localparam int          EW = WIDTH + 1;
    localparam logic [15:0] NV = 16'(NUM_VECTORS);

    state_t state, state_nxt;

    logic          mode_q;
    logic          mode_now;
    logic [VW-1:0] cnt;
    logic [VW-1:0] lfsr_lo;
    logic [VW-1:0] vec;
    logic          accept;
    logic          issue;
    logic          pending;
    logic          final_cmp;

    logic [WIDTH-1:0] va, vb;
    logic             vc;
    logic [EW-1:0]    exp_now;
    logic [EW-1:0]    dut_sum;

    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;

    logic [LAT:0]  vld;
    logic [LAT:0]  vld_others;
    logic [EW-1:0] pipe [0:LAT];

    tc_lfsr32 #(
        .SEED  (SEED),
        .TAPS  (LFSR_TAPS),
        .OUT_W (VW)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (issue),
        .value (lfsr_lo)
    );

    // Vector 0 leaves on the same edge that accepts start, so the mode input is used directly then.
    assign accept   = ((state == IDLE) || (state == DONE)) && start;
    assign issue    = accept || ((state == RUN) && (vec_count < NV));
    assign mode_now = accept ? mode : mode_q;

    always_comb begin
        vec = lfsr_lo;
        if (mode_now == MODE_COUNT) begin
            vec = accept ? '0 : cnt;
        end
    end

    assign {va, vb, vc} = vec;
    assign exp_now      = EW'(va) + EW'(vb) + EW'(vc);
    assign dut_sum      = {bus.Cout, bus.S};

    assign chk_valid = vld[LAT];

    // The last compare is the exiting entry with nothing queued behind it and nothing left to issue.
    always_comb begin
        vld_others      = vld;
        vld_others[LAT] = 1'b0;
    end
    assign pending   = |vld_others;
    assign final_cmp = chk_valid && !pending && !issue;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                if (final_cmp) begin
                    state_nxt = DONE;
                end else if ((LAT != 0) && (vec_count >= NV - 16'd1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (final_cmp) state_nxt = DONE;
            end
            DONE: begin
                if (accept) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_LFSR;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            match     <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            vld       <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            state <= state_nxt;

            if (accept) begin
                mode_q    <= mode;
                cnt       <= VW'(1);
                vec_count <= 16'd1;
            end else if (issue) begin
                cnt       <= cnt + VW'(1);
                vec_count <= vec_count + 16'd1;
            end

            if (issue) begin
                a_q   <= va;
                b_q   <= vb;
                cin_q <= vc;
            end

            vld[0]  <= issue;
            pipe[0] <= exp_now;
            for (int i = 1; i <= LAT; i++) begin
                vld[i]  <= vld[i-1];
                pipe[i] <= pipe[i-1];
            end

            if (accept) begin
                match     <= 1'b0;
                err_count <= '0;
            end else if (chk_valid) begin
                if (pipe[LAT] == dut_sum) begin
                    match <= 1'b1;
                end else begin
                    match <= 1'b0;
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.A   = a_q;
    assign bus.B   = b_q;
    assign bus.Cin = cin_q;

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_tc_adder_checker.sv
// tb/tb_tc_adder_checker.sv - table-driven scoreboard bench for tc_adder_checker
module tb_tc_adder_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic mode;
    int   sel;
    int   dl_a;
    bit   fault;

    int tests = 0;
    int fails = 0;

    tc_adder_checker_if #(.WIDTH(8)) ifa ();
    tc_adder_checker_if #(.WIDTH(4)) ifb ();
    tc_adder_checker_if #(.WIDTH(8)) ifc ();

    logic [2:0]  st;
    logic [2:0]  m_o, cv_o, b_o, d_o, p_o;
    logic [15:0] e_o [3];
    logic [15:0] v_o [3];

    always_comb begin
        st = '0;
        if (start) st[sel] = 1'b1;
    end

    tc_adder_checker #(.WIDTH(8), .LAT(1), .NUM_VECTORS(20), .SEED(32'h1)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .mode(mode), .bus(ifa.master),
        .match(m_o[0]), .chk_valid(cv_o[0]), .busy(b_o[0]), .done(d_o[0]), .pass(p_o[0]),
        .err_count(e_o[0]), .vec_count(v_o[0]));

    tc_adder_checker #(.WIDTH(4), .LAT(0), .NUM_VECTORS(512), .SEED(32'hACE1)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .mode(mode), .bus(ifb.master),
        .match(m_o[1]), .chk_valid(cv_o[1]), .busy(b_o[1]), .done(d_o[1]), .pass(p_o[1]),
        .err_count(e_o[1]), .vec_count(v_o[1]));

    tc_adder_checker #(.WIDTH(8), .LAT(2), .NUM_VECTORS(512), .SEED(32'h1234_5678)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .mode(mode), .bus(ifc.master),
        .match(m_o[2]), .chk_valid(cv_o[2]), .busy(b_o[2]), .done(d_o[2]), .pass(p_o[2]),
        .err_count(e_o[2]), .vec_count(v_o[2]));

    // Adder models: a has selectable latency 1/2, b is combinational, c has latency 2.
    logic [8:0] a_s0, a_d1, a_d2, a_out;
    logic [8:0] c_s0, c_d1, c_d2, c_out;
    assign a_s0 = 9'(ifa.A) + 9'(ifa.B) + 9'(ifa.Cin);
    assign c_s0 = 9'(ifc.A) + 9'(ifc.B) + 9'(ifc.Cin);
    always @(posedge clk) begin
        a_d1 <= a_s0;
        a_d2 <= a_d1;
        c_d1 <= c_s0;
        c_d2 <= c_d1;
    end
    always_comb begin
        a_out = (dl_a == 2) ? a_d2 : a_d1;
        c_out = c_d2;
        if (fault) begin
            a_out[3] = 1'b0;
            c_out[3] = 1'b0;
        end
    end
    assign {ifa.Cout, ifa.S} = a_out;
    assign {ifc.Cout, ifc.S} = c_out;
    assign {ifb.Cout, ifb.S} = 5'(ifb.A) + 5'(ifb.B) + 5'(ifb.Cin);

    logic [7:0]  v_A, v_B;
    logic        v_Cin;
    always_comb begin
        v_A = ifa.A; v_B = ifa.B; v_Cin = ifa.Cin;
        if (sel == 1) begin
            v_A = 8'(ifb.A); v_B = 8'(ifb.B); v_Cin = ifb.Cin;
        end else if (sel == 2) begin
            v_A = ifc.A; v_B = ifc.B; v_Cin = ifc.Cin;
        end
    end

    int          w_of   [3] = '{8, 4, 8};
    int          lat_of [3] = '{1, 0, 2};
    int          n_of   [3] = '{20, 512, 512};
    logic [31:0] seed_of[3] = '{32'h1, 32'hACE1, 32'h1234_5678};
    logic [31:0] lfsr_m [3];

    logic [31:0] vq [$];
    bit          mq [$];

    typedef struct {
        int s;
        bit md;
        int dl;
        bit flt;
        bit chk_m;
        bit err_nz;
        bit poke;
    } row_t;

    row_t        rows [8];
    logic [31:0] act_first [8];
    logic [31:0] dummy_first;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic run_vectors(input row_t r, output logic [31:0] first_got);
        int          n, l, w, errs, last;
        logic [31:0] v, vmask, wmask, got, expv, last_v;
        logic [8:0]  tsum;
        bit          mis;
        n = n_of[r.s]; l = lat_of[r.s]; w = w_of[r.s];
        vmask = (32'h1 << (2 * w + 1)) - 32'h1;
        wmask = (32'h1 << w) - 32'h1;
        sel = r.s; mode = r.md; dl_a = r.dl; fault = r.flt;
        errs = 0; first_got = '0; last_v = '0;
        vq.delete(); mq.delete();
        for (int j = 0; j < n; j++) begin
            v = r.md ? 32'(j) : lfsr_m[r.s];
            lfsr_m[r.s] = lfsr_step(lfsr_m[r.s]);
            v = v & vmask;
            vq.push_back(v);
            last_v = v;
            tsum = 9'((v >> (w + 1)) & wmask) + 9'((v >> 1) & wmask) + 9'(v & 32'h1);
            mis = r.flt && tsum[3];
            if (mis) errs++;
            mq.push_back(!mis);
        end
        start = 1'b1;
        @(negedge clk);
        last = n + l + 1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            start = 1'b0;
            if (cyc == 1) begin
                check("err_cleared", 32'(e_o[sel]), 32'h0);
                check("done_cleared", 32'(d_o[sel]), 32'h0);
            end
            if (cyc <= n) begin
                got  = (32'(v_A) << (w + 1)) | (32'(v_B) << 1) | 32'(v_Cin);
                expv = vq.pop_front();
                if (cyc == 1) first_got = got;
                check("vector", got, expv);
            end
            check("chk_valid", 32'(cv_o[sel]), 32'((cyc >= 1 + l) && (cyc <= n + l)));
            if (r.chk_m && cyc >= 2 + l && cyc <= n + l + 1) begin
                check("match", 32'(m_o[sel]), 32'(mq.pop_front()));
            end
            check("busy", 32'(b_o[sel]), 32'(cyc <= n + l));
            check("done", 32'(d_o[sel]), 32'(cyc == last));
            if (r.poke && l > 0 && cyc == n) start = 1'b1;
            if (cyc < last) @(negedge clk);
        end
        start = 1'b0;
        if (r.err_nz) begin
            check("err_nonzero", 32'(e_o[sel] != 16'd0), 32'h1);
            check("pass", 32'(p_o[sel]), 32'h0);
        end else begin
            check("err_count", 32'(e_o[sel]), 32'(errs));
            check("pass", 32'(p_o[sel]), 32'(errs == 0));
        end
        check("vec_count", 32'(v_o[sel]), 32'(n));
        got = (32'(v_A) << (w + 1)) | (32'(v_B) << 1) | 32'(v_Cin);
        check("held_vector", got, last_v);
        vq.delete(); mq.delete();
    endtask

    initial begin
        rows[0] = '{s:0, md:0, dl:1, flt:0, chk_m:1, err_nz:0, poke:0};
        rows[1] = '{s:0, md:1, dl:1, flt:0, chk_m:1, err_nz:0, poke:1};
        rows[2] = '{s:0, md:0, dl:2, flt:0, chk_m:0, err_nz:1, poke:0};
        rows[3] = '{s:0, md:0, dl:1, flt:0, chk_m:1, err_nz:0, poke:0};
        rows[4] = '{s:1, md:1, dl:1, flt:0, chk_m:1, err_nz:0, poke:0};
        rows[5] = '{s:2, md:1, dl:1, flt:1, chk_m:1, err_nz:0, poke:1};
        rows[6] = '{s:2, md:0, dl:1, flt:0, chk_m:1, err_nz:0, poke:0};
        rows[7] = '{s:0, md:1, dl:1, flt:1, chk_m:1, err_nz:0, poke:0};

        rst = 1'b1; start = 1'b0; mode = 1'b0; sel = 0; dl_a = 1; fault = 1'b0;
        for (int i = 0; i < 3; i++) lfsr_m[i] = seed_of[i];
        repeat (3) @(negedge clk);
        check("rst_A", 32'(v_A), 32'h0);
        check("rst_busy", 32'(b_o[0]), 32'h0);
        check("rst_done", 32'(d_o[0]), 32'h0);
        check("rst_vec", 32'(v_o[0]), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            run_vectors(rows[r], act_first[r]);
        end
        check("new_first_vector", 32'(act_first[3] != act_first[0]), 32'h1);

        // Reset in the middle of a run, then restart from a clean state.
        sel = 0; mode = 1'b0; dl_a = 1; fault = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int k;
            for (k = 0; k < 30; k++) begin
                if (v_o[0] == 16'd5) break;
                @(negedge clk);
            end
            check("reach_vec5", 32'(k < 30), 32'h1);
        end
        check("mid_busy", 32'(b_o[0]), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_A", 32'(v_A), 32'h0);
        check("mrst_B", 32'(v_B), 32'h0);
        check("mrst_Cin", 32'(v_Cin), 32'h0);
        check("mrst_match", 32'(m_o[0]), 32'h0);
        check("mrst_chk", 32'(cv_o[0]), 32'h0);
        check("mrst_busy", 32'(b_o[0]), 32'h0);
        check("mrst_done", 32'(d_o[0]), 32'h0);
        check("mrst_pass", 32'(p_o[0]), 32'h0);
        check("mrst_err", 32'(e_o[0]), 32'h0);
        check("mrst_vec", 32'(v_o[0]), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) lfsr_m[i] = seed_of[i];
        repeat (3) begin
            @(negedge clk);
            check("post_rst_chk", 32'(cv_o[0]), 32'h0);
            check("post_rst_busy", 32'(b_o[0]), 32'h0);
        end
        run_vectors(rows[0], dummy_first);
        check("restart_first_vector", dummy_first, act_first[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
